// File: rtl/mips_main_ctrl.sv
// Multicycle MIPS main control FSM with ALU-control decode for the R-type funct field.
// Optional macro MIPS_CTRL_BNE_EN adds the bne path (state BNEEX, code 12).
module mips_main_ctrl #(
  parameter int ALU_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [ALU_W-1:0] alu_sel,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(3'b000);
  localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(3'b001);
  localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(3'b010);
  localparam logic [ALU_W-1:0] ALU_SRLV = ALU_W'(3'b011);
  localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(3'b110);
  localparam logic [ALU_W-1:0] ALU_SLT  = ALU_W'(3'b111);

  // Unknown funct codes fall back to ADD; the FSM separately suppresses their writeback.
  function automatic logic [ALU_W-1:0] funct_to_alu(input logic [5:0] f);
    logic [ALU_W-1:0] sel;
    case (f)
      6'b100000: sel = ALU_ADD;
      6'b100010: sel = ALU_SUB;
      6'b100100: sel = ALU_AND;
      6'b100101: sel = ALU_OR;
      6'b101010: sel = ALU_SLT;
      6'b000110: sel = ALU_SRLV;
      default:   sel = ALU_ADD;
    endcase
    return sel;
  endfunction

  function automatic logic funct_legal(input logic [5:0] f);
    logic ok;
    case (f)
      6'b100000, 6'b100010, 6'b100100,
      6'b100101, 6'b101010, 6'b000110: ok = 1'b1;
      default:                         ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t state_r;
  state_t state_nxt_s;

  logic             pc_en_s;
  logic             iord_s;
  logic             mem_write_s;
  logic             ir_write_s;
  logic             reg_dst_s;
  logic             mem_to_reg_s;
  logic             reg_write_s;
  logic             alu_src_a_s;
  logic [1:0]       alu_src_b_s;
  logic [1:0]       pc_src_s;
  logic [ALU_W-1:0] alu_sel_s;

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = FETCH;
    case (state_r)
      FETCH: state_nxt_s = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt_s = MEMADR;
          OP_RTYPE:     state_nxt_s = RTYPEEX;
          OP_BEQ:       state_nxt_s = BEQEX;
          OP_ADDI:      state_nxt_s = ADDIEX;
          OP_J:         state_nxt_s = JEX;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_nxt_s = BNEEX;
`endif
          default:      state_nxt_s = FETCH;
        endcase
      end
      MEMADR: begin
        if (opcode == OP_LW) begin
          state_nxt_s = MEMRD;
        end else begin
          state_nxt_s = MEMWR;
        end
      end
      MEMRD: state_nxt_s = MEMWB;
      RTYPEEX: begin
        if (funct_legal(funct)) begin
          state_nxt_s = RTYPEWB;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      ADDIEX:  state_nxt_s = ADDIWB;
      default: state_nxt_s = FETCH;
    endcase
  end

  // Control decode: Moore from state, except branch pc_en (zero) and R-type alu_sel (funct).
  always_comb begin
    pc_en_s      = 1'b0;
    iord_s       = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    pc_src_s     = 2'b00;
    alu_sel_s    = ALU_ADD;
    case (state_r)
      FETCH: begin
        alu_src_b_s = 2'b01;
        ir_write_s  = 1'b1;
        pc_en_s     = 1'b1;
      end
      DECODE: alu_src_b_s = 2'b11;
      MEMADR, ADDIEX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      MEMRD: iord_s = 1'b1;
      MEMWB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
      end
      MEMWR: begin
        iord_s      = 1'b1;
        mem_write_s = 1'b1;
      end
      RTYPEEX: begin
        alu_src_a_s = 1'b1;
        alu_sel_s   = funct_to_alu(funct);
      end
      RTYPEWB: begin
        reg_dst_s   = 1'b1;
        reg_write_s = 1'b1;
      end
      BEQEX: begin
        alu_src_a_s = 1'b1;
        alu_sel_s   = ALU_SUB;
        pc_src_s    = 2'b01;
        pc_en_s     = zero;
      end
      ADDIWB: reg_write_s = 1'b1;
      JEX: begin
        pc_src_s = 2'b10;
        pc_en_s  = 1'b1;
      end
`ifdef MIPS_CTRL_BNE_EN
      BNEEX: begin
        alu_src_a_s = 1'b1;
        alu_sel_s   = ALU_SUB;
        pc_src_s    = 2'b01;
        pc_en_s     = ~zero;
      end
`endif
      default: begin
        pc_en_s = 1'b0;
      end
    endcase
  end

  // Architectural write strobes are held off for the whole time reset is asserted.
  assign pc_en      = pc_en_s & rst_n;
  assign ir_write   = ir_write_s & rst_n;
  assign reg_write  = reg_write_s & rst_n;
  assign mem_write  = mem_write_s & rst_n;
  assign iord       = iord_s;
  assign reg_dst    = reg_dst_s;
  assign mem_to_reg = mem_to_reg_s;
  assign alu_src_a  = alu_src_a_s;
  assign alu_src_b  = alu_src_b_s;
  assign pc_src     = pc_src_s;
  assign alu_sel    = alu_sel_s;
  assign state_o    = state_r;

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Randomized self-checking bench for mips_main_ctrl against an instruction-level model.
// Honours MIPS_CTRL_BNE_EN when the same macro is defined for the build.
module tb_mips_main_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_sel;
  logic [3:0] state_o;

  int total_cnt = 0;
  int bad_cnt   = 0;

`ifdef MIPS_CTRL_BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  // Legal R-type functs and the ALU codes they select, as plain lookup tables.
  logic [5:0] legal_fn  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000110};
  logic [2:0] legal_alu [6] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b011};
  logic [5:0] op_pool   [9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                                6'b000010, 6'b000101, 6'b111111, 6'b000001};

  mips_main_ctrl #(.ALU_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_sel(alu_sel), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fn_index(input logic [5:0] fn);
    for (int i = 0; i < 6; i++) if (legal_fn[i] == fn) return i;
    return -1;
  endfunction

  // Expected state walk for one instruction, straight from the per-instruction latency rules.
  function automatic void build_seq(input logic [5:0] op, input logic [5:0] fn, output int seq[$]);
    seq = {};
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: if (fn_index(fn) >= 0) seq = '{0, 1, 6, 7}; else seq = '{0, 1, 6};
      6'b000100: seq = '{0, 1, 8};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000010: seq = '{0, 1, 11};
      6'b000101: if (BNE_ON) seq = '{0, 1, 12}; else seq = '{0, 1};
      default:   seq = '{0, 1};
    endcase
  endfunction

  // Expected control word {pc_en,iord,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
  // alu_src_a,alu_src_b,pc_src,alu_sel} for a given phase of an instruction.
  function automatic logic [14:0] exp_ctl(input int st, input logic [5:0] fn, input logic z);
    logic pe, io, mw, iw, rd, m2r, rw, sa;
    logic [1:0] sb, ps;
    logic [2:0] as;
    int idx;
    {pe, io, mw, iw, rd, m2r, rw, sa} = 8'h00;
    sb = 2'b00; ps = 2'b00; as = 3'b010;
    case (st)
      0:  begin sb = 2'b01; iw = 1'b1; pe = 1'b1; end
      1:  sb = 2'b11;
      2, 9: begin sa = 1'b1; sb = 2'b10; end
      3:  io = 1'b1;
      4:  begin m2r = 1'b1; rw = 1'b1; end
      5:  begin io = 1'b1; mw = 1'b1; end
      6:  begin
            sa = 1'b1;
            idx = fn_index(fn);
            if (idx >= 0) as = legal_alu[idx];
          end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin sa = 1'b1; as = 3'b110; ps = 2'b01; pe = z; end
      10: rw = 1'b1;
      11: begin ps = 2'b10; pe = 1'b1; end
      12: begin sa = 1'b1; as = 3'b110; ps = 2'b01; pe = ~z; end
      default: pe = 1'b0;
    endcase
    return {pe, io, mw, iw, rd, m2r, rw, sa, sb, ps, as};
  endfunction

  function automatic logic [14:0] obs_ctl();
    return {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
            alu_src_a, alu_src_b, pc_src, alu_sel};
  endfunction

  // Walks one instruction cycle by cycle; abort_at >= 0 drops reset after that step's checks.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int abort_at,
                           input int zmode);
    int seq[$];
    build_seq(op, fn, seq);
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        opcode = op;
        funct  = fn;
      end
      if (zmode == 0) zero = 1'b0;
      else if (zmode == 1) zero = 1'b1;
      else zero = 1'($urandom_range(1, 0));
      #1;
      chk("state", 32'(state_o), 32'(seq[i]));
      chk("ctl", 32'(obs_ctl()), 32'(exp_ctl(seq[i], fn, zero)));
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_state", 32'(state_o), 32'd0);
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_strobes", 32'({pc_en, ir_write, reg_write}), 32'd0);
        chk("abort_src_b", 32'(alu_src_b), 32'd1);
        return;
      end
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] op, fn;
    rst_n  = 1'b0;
    opcode = 6'd0;
    funct  = 6'd0;
    zero   = 1'b0;
    #3;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_strobes", 32'({pc_en, ir_write, reg_write, mem_write}), 32'd0);
    chk("rst_src_b", 32'(alu_src_b), 32'd1);
    chk("rst_alu_sel", 32'(alu_sel), 32'd2);
    release_reset();

    run_instr(6'b100011, 6'd0, -1, 2);          // lw
    run_instr(6'b000000, 6'b000110, -1, 2);     // srlv
    run_instr(6'b000000, 6'b101010, -1, 2);     // slt
    run_instr(6'b000000, 6'b100010, -1, 2);     // sub
    run_instr(6'b000100, 6'd0, -1, 1);          // beq taken
    run_instr(6'b000100, 6'd0, -1, 0);          // beq not taken
    run_instr(6'b111111, 6'd0, -1, 2);          // illegal opcode
    run_instr(6'b000000, 6'b111111, -1, 2);     // illegal funct
    run_instr(6'b000101, 6'd0, -1, 0);          // bne, zero=0
    run_instr(6'b001000, 6'd0, -1, 2);          // addi
    run_instr(6'b000010, 6'd0, -1, 2);          // j
    run_instr(6'b101011, 6'd0, 3, 2);           // sw, reset dropped in MEMWR
    release_reset();

    for (int n = 0; n < 200; n++) begin
      op = op_pool[$urandom_range(8, 0)];
      if (op == 6'b000001) op = 6'($urandom);
      if ($urandom_range(1, 0) == 0) fn = legal_fn[$urandom_range(5, 0)];
      else fn = 6'($urandom);
      if (n % 50 == 49) begin
        run_instr(op, fn, int'($urandom_range(1, 0)), 2);
        release_reset();
      end else begin
        run_instr(op, fn, -1, 2);
      end
    end

    @(negedge clk);
    #1;
    chk("final_state", 32'(state_o), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/mips_main_ctrl.md
Name: mips_main_ctrl

Overview:
Multicycle MIPS main control unit and ALU-control decoder. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and generates every datapath enable and mux select. It also drives the ALU's 3-bit operation select and consumes the ALU zero flag for branches. It sits beside the datapath, between the instruction register fields and the ALU, register file, memory and PC.

Parameters:
ALU_W, 3, width of alu_sel; fixed encoding AND=000 OR=001 ADD=010 SRLV=011 SUB=110 SLT=111

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from IR; stable from DECODE until return to FETCH
funct  in  6  instr[5:0] from IR; same stability
zero  in  1  ALU zero flag (ALU out == 0)
pc_en  out  1  PC write enable (includes branch qualification)
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_write  out  1  data memory write
ir_write  out  1  IR load
reg_dst  out  1  write register: 0=rt, 1=rd
mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  00=reg B, 01=4, 10=signext imm, 11=signext imm<<2
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
alu_sel  out  3  ALU operation
state_o  out  4  current state code (debug/verification)

Behaviour:
- States and codes: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 RTYPEEX=6 RTYPEWB=7 BEQEX=8 ADDIEX=9 ADDIWB=10 JEX=11 BNEEX=12.
- Reset: state=FETCH asynchronously. While rst_n=0, pc_en, ir_write, reg_write and mem_write are forced 0. All other outputs show the FETCH decode.
- Transitions:
  - FETCH->DECODE always.
  - DECODE branches on opcode: 100011 lw or 101011 sw->MEMADR; 000000->RTYPEEX; 000100->BEQEX; 001000->ADDIEX; 000010->JEX; anything else->FETCH, with no writes.
  - MEMADR->MEMRD (lw) or MEMWR (sw). MEMRD->MEMWB.
  - RTYPEEX->RTYPEWB only if funct is legal; otherwise ->FETCH.
  - ADDIEX->ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX, BNEEX->FETCH.
- Output defaults: every output 0 and alu_sel=ADD unless listed for the state below.
  - FETCH: alu_src_b=01, ir_write=1, pc_en=1.
  - DECODE: alu_src_b=11.
  - MEMADR, ADDIEX: alu_src_a=1, alu_src_b=10.
  - MEMRD: iord=1.
  - MEMWB: mem_to_reg=1, reg_write=1.
  - MEMWR: iord=1, mem_write=1.
  - RTYPEEX: alu_src_a=1, alu_sel from funct.
  - RTYPEWB: reg_dst=1, reg_write=1.
  - BEQEX: alu_src_a=1, alu_sel=SUB, pc_src=01, pc_en=zero (combinational, same cycle).
  - ADDIWB: reg_write=1.
  - JEX: pc_src=10, pc_en=1.
- Funct decode in RTYPEEX: 100000->ADD, 100010->SUB, 100100->AND, 100101->OR, 101010->SLT, 000110->SRLV (ALU computes B>>A, i.e. rt>>rs). Any other funct: alu_sel=ADD and no writeback.
- Output timing:
  - Only pc_en (via zero) and alu_sel (via funct) are Mealy; all other outputs decode from state only.
  - No output is ever X.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal opcode 2.
- Reset asserted mid-instruction aborts it immediately; the next instruction starts in FETCH after rst_n deasserts.

Optional Feature:
MIPS_CTRL_BNE_EN
- Defined: DECODE with opcode 000101 goes to BNEEX. BNEEX is BEQEX with pc_en = ~zero.
- Undefined: opcode 000101 is illegal (DECODE->FETCH). State code 12 is unreachable.

Test Plan:
- Reset then lw (opcode 100011): state_o 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. iord=1 in state 3.
- R-type opcode 000000, funct 000110: alu_sel=011 in state 6, then reg_dst=1 and reg_write=1 in state 7. Repeat for funct 101010 (expect 111) and 100010 (expect 110).
- beq with zero=1: pc_en=1, pc_src=01 in state 8. With zero=0: pc_en=0. Next state is FETCH in both cases.
- Illegal opcode 111111: DECODE->FETCH with no reg_write or mem_write. R-type funct 111111: RTYPEEX->FETCH, no reg_write.
- Drop rst_n in MEMWR mid-cycle: mem_write falls immediately and state_o=0. After release, FETCH outputs appear: alu_src_b=01, ir_write=1.
- opcode 000101 with zero=0: with macro defined, state 12 and pc_en=1. Without it, DECODE->FETCH and pc_en stays 0.
